io1in_pad_ctrl: RTL and testbench

- Controller in front of the single-bit input pad.
- Synchronises and debounces `top_pin`, detects qualified edges, and delivers each edge event independently to NUM_CONSUMERS requesters over per-consumer valid/ready handshakes.
- Replaces raw fan-out of the pad to `pin_0..pin_3` with sequenced, lossless-or-flagged delivery.

---
 rtl/io_pad_pkg.sv | 16 +
 rtl/io_sync2.sv | 24 ++
 rtl/io1in_pad_ctrl.sv | 131 +++++++++++++
 tb/tb_io1in_pad_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared constants for the input-pad controller: debounce FSM states,
// edge-select encodings and edge-type encodings.
package io_pad_pkg;

    localparam logic [0:0] STABLE   = 1'b0;
    localparam logic [0:0] SETTLING = 1'b1;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam logic EDGE_T_FALL = 1'b0;
    localparam logic EDGE_T_RISE = 1'b1;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, with a reset value
// so the synchronised output matches the controller's initial level.
module io_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io1in_pad_ctrl.sv
// Input-pad controller: sync, debounce, edge qualify, per-consumer delivery.
// Define IO1IN_PAD_CTRL_GLITCH_CNT_EN to add the saturating glitch counter.
//
// state    | meaning
// STABLE   | synchronised pad matches pin_level
// SETTLING | pad differs from pin_level, counting stable cycles
module io1in_pad_ctrl
    import io_pad_pkg::*;
#(
    parameter int   NUM_CONSUMERS   = 4,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:0]               top_pin,
    input  logic [1:0]               cfg_edge_sel,
    input  logic [NUM_CONSUMERS-1:0] cfg_en,
    output logic [NUM_CONSUMERS-1:0] pin_valid,
    input  logic [NUM_CONSUMERS-1:0] pin_ready,
    output logic [NUM_CONSUMERS-1:0] pin_edge,
    output logic                     pin_level,
    output logic [NUM_CONSUMERS-1:0] ovf,
    input  logic [NUM_CONSUMERS-1:0] ovf_clr
`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
    ,
    output logic [7:0]               glitch_cnt,
    input  logic                     glitch_cnt_clr
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          sync;
    logic          differ;
    logic          glitch;
    logic          commit;
    logic          qual_ev;
    logic          ev_type;

    io_sync2 #(.RST_VAL(INIT_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (top_pin[0]),
        .q   (sync)
    );

    always_comb begin
        differ  = sync ^ pin_level;
        glitch  = (state == SETTLING) && !differ;
        commit  = (state == SETTLING) && differ && (cnt == CNT_LAST);
        ev_type = sync ? EDGE_T_RISE : EDGE_T_FALL;
        qual_ev = commit && (sync ? |(cfg_edge_sel & EDGE_RISE)
                                  : |(cfg_edge_sel & EDGE_FALL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= STABLE;
            cnt       <= '0;
            pin_level <= INIT_LEVEL;
        end else begin
            case (state)
                STABLE: begin
                    if (differ) begin
                        state <= SETTLING;
                        cnt   <= '0;
                    end
                end
                SETTLING: begin
                    if (!differ) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        pin_level <= sync;
                        state     <= STABLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Each consumer owns its slot; a stall on one never gates another.
    for (genvar gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pin_valid[gi] <= 1'b0;
                pin_edge[gi]  <= 1'b0;
                ovf[gi]       <= 1'b0;
            end else begin
                if (ovf_clr[gi])
                    ovf[gi] <= 1'b0;
                if (!cfg_en[gi]) begin
                    pin_valid[gi] <= 1'b0;
                end else if (qual_ev) begin
                    if (pin_valid[gi] && !pin_ready[gi])
                        ovf[gi] <= 1'b1;
                    pin_valid[gi] <= 1'b1;
                    pin_edge[gi]  <= ev_type;
                end else if (pin_valid[gi] && pin_ready[gi]) begin
                    pin_valid[gi] <= 1'b0;
                end
            end
        end
    end

`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            glitch_cnt <= 8'd0;
        else if (glitch_cnt_clr)
            glitch_cnt <= 8'd0;
        else if (glitch && (glitch_cnt != 8'hFF))
            glitch_cnt <= glitch_cnt + 8'd1;
    end
`else
    logic unused_glitch;
    assign unused_glitch = glitch;
`endif

endmodule

// File: tb/tb_io1in_pad_ctrl.sv
// Directed bench for io1in_pad_ctrl (4 consumers, 8-cycle debounce, init 0).
// Checks glitch_cnt too when IO1IN_PAD_CTRL_GLITCH_CNT_EN is defined.
module tb_io1in_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] top_pin;
    logic [1:0] cfg_edge_sel;
    logic [3:0] cfg_en;
    logic [3:0] pin_valid;
    logic [3:0] pin_ready;
    logic [3:0] pin_edge;
    logic       pin_level;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
    logic       glitch_cnt_clr;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    io1in_pad_ctrl #(
        .NUM_CONSUMERS   (4),
        .DEBOUNCE_CYCLES (8),
        .INIT_LEVEL      (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .top_pin      (top_pin),
        .cfg_edge_sel (cfg_edge_sel),
        .cfg_en       (cfg_en),
        .pin_valid    (pin_valid),
        .pin_ready    (pin_ready),
        .pin_edge     (pin_edge),
        .pin_level    (pin_level),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
        ,
        .glitch_cnt     (glitch_cnt),
        .glitch_cnt_clr (glitch_cnt_clr)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        top_pin      = 1'b0;
        cfg_edge_sel = 2'b11;
        cfg_en       = 4'b1111;
        pin_ready    = 4'b0000;
        ovf_clr      = 4'b0000;
`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
        glitch_cnt_clr = 1'b0;
`endif
        step(3);
        chk("rst_level", {7'd0, pin_level}, 8'h0);
        chk("rst_valid", {4'd0, pin_valid}, 8'h0);
        chk("rst_edge",  {4'd0, pin_edge},  8'h0);
        chk("rst_ovf",   {4'd0, ovf},       8'h0);
        rst = 1'b1;
        step(2);

        // rise: level/valid change on edge k+10
        top_pin = 1'b1;
        step(10);
        chk("rise_early_level", {7'd0, pin_level}, 8'h0);
        chk("rise_early_valid", {4'd0, pin_valid}, 8'h0);
        step(1);
        chk("rise_level", {7'd0, pin_level}, 8'h1);
        chk("rise_valid", {4'd0, pin_valid}, 8'hF);
        chk("rise_edge",  {4'd0, pin_edge},  8'hF);
        pin_ready = 4'b1111;
        step(1);
        pin_ready = 4'b0000;
        chk("rise_accept", {4'd0, pin_valid}, 8'h0);

        // 5-cycle glitch low
        top_pin = 1'b0;
        step(5);
        top_pin = 1'b1;
        step(20);
        chk("glitch_level", {7'd0, pin_level}, 8'h1);
        chk("glitch_valid", {4'd0, pin_valid}, 8'h0);
`ifdef IO1IN_PAD_CTRL_GLITCH_CNT_EN
        chk("glitch_cnt", glitch_cnt, 8'd1);
`endif

        // rise-only selection
        cfg_edge_sel = 2'b01;
        top_pin = 1'b0;
        step(11);
        chk("sel_fall_level", {7'd0, pin_level}, 8'h0);
        chk("sel_fall_valid", {4'd0, pin_valid}, 8'h0);
        top_pin = 1'b1;
        step(11);
        chk("sel_rise_valid", {4'd0, pin_valid}, 8'hF);
        chk("sel_rise_edge",  {4'd0, pin_edge},  8'hF);
        pin_ready = 4'b1111;
        step(1);
        pin_ready = 4'b0000;
        top_pin = 1'b0;
        step(11);
        chk("sel_fall2_level", {7'd0, pin_level}, 8'h0);
        chk("sel_fall2_valid", {4'd0, pin_valid}, 8'h0);

        // consumer 2 stalled across two events
        cfg_edge_sel = 2'b11;
        pin_ready = 4'b1011;
        top_pin = 1'b1;
        step(11);
        chk("stall_rise_valid", {4'd0, pin_valid}, 8'hF);
        chk("stall_rise_edge",  {4'd0, pin_edge},  8'hF);
        step(1);
        chk("stall_drain", {4'd0, pin_valid}, 8'h4);
        top_pin = 1'b0;
        step(11);
        chk("stall_fall_valid", {4'd0, pin_valid}, 8'hF);
        chk("stall_fall_edge",  {4'd0, pin_edge},  8'h0);
        chk("stall_ovf",        {4'd0, ovf},       8'h4);
        ovf_clr = 4'b0100;
        step(1);
        ovf_clr = 4'b0000;
        chk("ovf_clr", {4'd0, ovf}, 8'h0);
        chk("stall_valid2", {4'd0, pin_valid}, 8'h4);
        pin_ready = 4'b1111;
        step(1);
        pin_ready = 4'b0000;
        chk("stall_release", {4'd0, pin_valid}, 8'h0);

        // accept and new event together on consumer 0
        top_pin = 1'b1;
        step(11);
        chk("acc_rise_valid", {4'd0, pin_valid}, 8'hF);
        top_pin = 1'b0;
        step(10);
        pin_ready = 4'b0001;
        step(1);
        pin_ready = 4'b0000;
        chk("acc_valid", {4'd0, pin_valid}, 8'hF);
        chk("acc_edge",  {4'd0, pin_edge},  8'h0);
        chk("acc_ovf",   {4'd0, ovf},       8'hE);

        // async reset while pending and settling
        top_pin = 1'b1;
        step(5);
        rst = 1'b0;
        #2;
        chk("mrst_valid", {4'd0, pin_valid}, 8'h0);
        chk("mrst_ovf",   {4'd0, ovf},       8'h0);
        chk("mrst_level", {7'd0, pin_level}, 8'h0);
        chk("mrst_edge",  {4'd0, pin_edge},  8'h0);
        step(2);
        rst = 1'b1;
        step(10);
        chk("post_rst_early_level", {7'd0, pin_level}, 8'h0);
        chk("post_rst_early_valid", {4'd0, pin_valid}, 8'h0);
        step(1);
        chk("post_rst_level", {7'd0, pin_level}, 8'h1);
        chk("post_rst_valid", {4'd0, pin_valid}, 8'hF);
        chk("post_rst_edge",  {4'd0, pin_edge},  8'hF);

        // disable discards pending without ovf, blocks new events
        cfg_en = 4'b0000;
        step(1);
        chk("dis_valid", {4'd0, pin_valid}, 8'h0);
        chk("dis_ovf",   {4'd0, ovf},       8'h0);
        top_pin = 1'b0;
        step(11);
        chk("dis_level", {7'd0, pin_level}, 8'h0);
        chk("dis_event", {4'd0, pin_valid}, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
